mmio_data_memory: RTL and testbench

- Parametrised next-generation data memory with memory-mapped GPIO for the RV32I core.
- Combines a byte-enabled word RAM with N_OUT writable output channels (read-back capable) and N_IN synchronised input channels with change-event flags.
- Presents one registered read port to the load/store unit.
- Sits between the core's data-memory interface and the board I/O (switches, buttons, LEDs, 7-segment displays).

---
 rtl/mmio_data_memory_pkg.sv | 24 ++
 rtl/mmio_data_memory_if.sv | 14 +
 rtl/mmio_data_memory_sync.sv | 30 +++
 rtl/mmio_data_memory.sv | 151 +++++++++++++++
 tb/tb_mmio_data_memory.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_data_memory_pkg.sv
// Shared definitions for the MMIO data memory: region codes, arming length
// and the byte-lane merge used by the writable registers.
package mmio_pkg;

  typedef enum logic [1:0] {
    REG_MEM = 2'b00,
    REG_IN  = 2'b01,
    REG_OUT = 2'b10,
    REG_EVT = 2'b11
  } region_e;

  localparam logic [1:0] ARM_CYCLES = 2'd3;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_data_memory_if.sv
// Load/store bus between the core and the data memory: word address,
// byte enables, write data/strobe and the registered read data.
interface mmio_data_memory_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteena;
  logic [31:0]       data;
  logic              wren;
  logic [31:0]       q;

  modport master (output address, byteena, data, wren, input q);
  modport slave  (input address, byteena, data, wren, output q);
endinterface

// File: rtl/mmio_data_memory_sync.sv
// One input channel: two-flop synchroniser, a one-cycle-delayed copy of the
// synchronised value, and a change flag comparing the two.
module io_input_sync #(
  parameter int IN_W = 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IN_W-1:0] din,
  output logic [IN_W-1:0] synced,
  output logic            changed
);
  logic [IN_W-1:0] meta_reg;
  logic [IN_W-1:0] sync_reg;
  logic [IN_W-1:0] prev_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_reg <= '0;
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign synced  = sync_reg;
  assign changed = (sync_reg != prev_reg);
endmodule

// File: rtl/mmio_data_memory.sv
// Data memory for the RV32I core: byte-enabled word RAM plus memory-mapped
// output channels, synchronised input channels and change-event flags.
module mmio_data_memory
  import mmio_pkg::*;
#(
  parameter int              ADDR_W    = 12,
  parameter int              MEM_AW    = 10,
  parameter int              N_OUT     = 7,
  parameter int              OUT_W     = 10,
  parameter logic [OUT_W-1:0] OUT_RESET = '0,
  parameter int              N_IN      = 5,
  parameter int              IN_W      = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  mmio_data_memory_if.slave      bus,
  input  logic [N_IN*IN_W-1:0]   io_input_bus,
  output logic [N_OUT*OUT_W-1:0] io_output_bus,
  output logic                   io_event
);

  region_e           region;
  logic [3:0]        idx;
  logic [MEM_AW-1:0] ram_idx;

  assign region  = region_e'(bus.address[ADDR_W-1 -: 2]);
  assign idx     = bus.address[3:0];
  assign ram_idx = bus.address[MEM_AW-1:0];

  // RAM: contents are never reset, but writes are suppressed while reset is high
  logic [31:0] mem [2**MEM_AW];
  logic [31:0] ram_q_reg;
  logic        ram_we;

  assign ram_we = bus.wren && (region == REG_MEM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_q_reg <= '0;
    end else begin
      ram_q_reg <= mem[ram_idx];
      for (int k = 0; k < 4; k++) begin
        if (ram_we && bus.byteena[k]) begin
          mem[ram_idx][8*k +: 8] <= bus.data[8*k +: 8];
        end
      end
    end
  end

  logic [N_OUT-1:0][OUT_W-1:0] out_vals;

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
    logic [OUT_W-1:0] ch_reg;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        ch_reg <= OUT_RESET;
      end else if (bus.wren && (region == REG_OUT) && (idx == 4'(gi))) begin
        ch_reg <= OUT_W'(byte_merge(32'(ch_reg), bus.data, bus.byteena));
      end
    end

    assign out_vals[gi]                      = ch_reg;
    assign io_output_bus[gi*OUT_W +: OUT_W]  = ch_reg;
  end

  logic [N_IN-1:0][IN_W-1:0] in_sync;
  logic [N_IN-1:0]           change_vec;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
    io_input_sync #(.IN_W(IN_W)) u_sync (
      .clock   (clock),
      .reset   (reset),
      .din     (io_input_bus[gi*IN_W +: IN_W]),
      .synced  (in_sync[gi]),
      .changed (change_vec[gi])
    );
  end

  // Full 16-entry read tables so unimplemented indices read as zero
  logic [15:0][31:0] out_rd;
  logic [15:0][31:0] in_rd;

  for (genvar gi = 0; gi < 16; gi++) begin : g_rd
    if (gi < N_OUT) begin : g_o
      assign out_rd[gi] = 32'(out_vals[gi]);
    end else begin : g_oz
      assign out_rd[gi] = '0;
    end
    if (gi < N_IN) begin : g_i
      assign in_rd[gi] = 32'(in_sync[gi]);
    end else begin : g_iz
      assign in_rd[gi] = '0;
    end
  end

  logic [1:0]      arm_cnt_reg;
  logic            armed;
  logic [N_IN-1:0] flags_reg;
  logic [N_IN-1:0] flags_next;
  logic [N_IN-1:0] clr;
  logic            event_reg;

  assign armed      = (arm_cnt_reg == ARM_CYCLES);
  assign clr        = (bus.wren && (region == REG_EVT)) ? bus.data[N_IN-1:0] : '0;
  // A fresh change beats a simultaneous write-1-to-clear
  assign flags_next = ({N_IN{armed}} & change_vec) | (flags_reg & ~clr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      arm_cnt_reg <= '0;
      flags_reg   <= '0;
      event_reg   <= 1'b0;
    end else begin
      if (!armed) begin
        arm_cnt_reg <= arm_cnt_reg + 2'd1;
      end
      flags_reg <= flags_next;
      event_reg <= |flags_reg;
    end
  end

  assign io_event = event_reg;

  logic [31:0] io_rd_next;
  logic [31:0] io_q_reg;
  logic        sel_ram_reg;

  always_comb begin
    io_rd_next = '0;
    case (region)
      REG_OUT: io_rd_next = out_rd[idx];
      REG_IN:  io_rd_next = in_rd[idx];
      REG_EVT: io_rd_next = 32'(flags_reg);
      default: io_rd_next = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_q_reg    <= '0;
      sel_ram_reg <= 1'b0;
    end else begin
      io_q_reg    <= io_rd_next;
      sel_ram_reg <= (region == REG_MEM);
    end
  end

  assign bus.q = sel_ram_reg ? ram_q_reg : io_q_reg;

endmodule

// File: tb/tb_mmio_data_memory.sv
// Randomised bench for mmio_data_memory against a cycle-level reference
// model built from delay lines, plain arrays and the region rules.
module tb_mmio_data_memory;

  localparam int ADDR_W = 12;
  localparam int MEM_AW = 10;
  localparam int N_OUT  = 7;
  localparam int OUT_W  = 10;
  localparam int N_IN   = 5;
  localparam int IN_W   = 10;

  logic                   clock;
  logic                   reset;
  logic [N_IN*IN_W-1:0]   io_in;
  logic [N_OUT*OUT_W-1:0] io_out;
  logic                   io_evt;

  mmio_data_memory_if #(.ADDR_W(ADDR_W)) bus ();

  mmio_data_memory #(
    .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .N_OUT(N_OUT), .OUT_W(OUT_W),
    .OUT_RESET('0), .N_IN(N_IN), .IN_W(IN_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .io_input_bus  (io_in),
    .io_output_bus (io_out),
    .io_event      (io_evt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0]          ram_m [16];
  bit                   ram_ok [16];
  logic [OUT_W-1:0]     out_m [N_OUT];
  logic [N_IN-1:0]      flags_m;
  logic [N_IN*IN_W-1:0] h1, h2, h3;   // input as applied 1, 2, 3 edges ago
  int                   edge_cnt;
  logic [31:0]          exp_q;
  bit                   exp_q_valid;
  logic                 exp_evt;

  task automatic model_reset();
    for (int i = 0; i < N_OUT; i++) out_m[i] = '0;
    flags_m  = '0;
    h1 = '0; h2 = '0; h3 = '0;
    edge_cnt = 0;
  endtask

  function automatic logic [N_OUT*OUT_W-1:0] exp_bus();
    logic [N_OUT*OUT_W-1:0] v;
    for (int i = 0; i < N_OUT; i++) v[i*OUT_W +: OUT_W] = out_m[i];
    return v;
  endfunction

  task automatic model_edge(input logic [11:0] a, input logic [3:0] be,
                            input logic [31:0] d, input logic w);
    int r, idx;
    logic [31:0] tmp;
    logic [N_IN-1:0] fn;
    r   = int'(a >> 10);
    idx = int'(a & 12'hF);
    edge_cnt++;
    exp_q_valid = 1;
    exp_q = '0;
    if (r == 0) begin
      exp_q = ram_m[idx];
      exp_q_valid = ram_ok[idx];
    end else if (r == 2) begin
      if (idx < N_OUT) exp_q = 32'(out_m[idx]);
    end else if (r == 1) begin
      if (idx < N_IN) exp_q = 32'(h2[idx*IN_W +: IN_W]);
    end else begin
      exp_q = 32'(flags_m);
    end
    exp_evt = |flags_m;
    // synced value is the input two edges old; prev is three edges old
    for (int i = 0; i < N_IN; i++) begin
      fn[i] = ((edge_cnt >= 4) && (h2[i*IN_W +: IN_W] != h3[i*IN_W +: IN_W])) ||
              (flags_m[i] && !(w && r == 3 && d[i]));
    end
    flags_m = fn;
    if (w && r == 0) begin
      for (int k = 0; k < 4; k++) if (be[k]) ram_m[idx][8*k +: 8] = d[8*k +: 8];
      if (be == 4'hF) ram_ok[idx] = 1;
    end
    if (w && r == 2 && idx < N_OUT) begin
      tmp = 32'(out_m[idx]);
      for (int k = 0; k < 4; k++) if (be[k]) tmp[8*k +: 8] = d[8*k +: 8];
      out_m[idx] = tmp[OUT_W-1:0];
    end
    h3 = h2; h2 = h1; h1 = io_in;
  endtask

  // One bus cycle: drive at the falling edge, model at the rising edge,
  // compare at the next falling edge.
  task automatic step(input logic [11:0] a, input logic [3:0] be,
                      input logic [31:0] d, input logic w);
    bus.address = a; bus.byteena = be; bus.data = d; bus.wren = w;
    @(posedge clock);
    model_edge(a, be, d, w);
    @(negedge clock);
    n_txn++;
    $display("txn %0d addr=%03h wren=%0d data=%08h q=%08h evt=%0d",
             n_txn, a, w, d, bus.q, io_evt);
    if (exp_q_valid) check("q", 128'(bus.q), 128'(exp_q));
    check("out_bus", 128'(io_out), 128'(exp_bus()));
    check("io_event", 128'(io_evt), 128'(exp_evt));
  endtask

  task automatic rd(input logic [11:0] a);
    step(a, 4'h0, 32'h0, 1'b0);
  endtask

  logic [N_OUT*OUT_W-1:0] snap;

  initial begin
    for (int i = 0; i < 16; i++) ram_ok[i] = 0;
    reset = 1'b1;
    bus.address = '0; bus.byteena = '0; bus.data = '0; bus.wren = 1'b0;
    io_in = N_IN*IN_W'({$urandom, $urandom}) | 1;
    io_in[2*IN_W +: IN_W] = 10'h0AA;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check("rst_q", 128'(bus.q), 128'h0);
    check("rst_out", 128'(io_out), 128'h0);
    check("rst_evt", 128'(io_evt), 128'h0);
    reset = 1'b0;
    model_reset();

    // Non-zero inputs through the arm window must not raise events
    for (int i = 0; i < 6; i++) rd(12'hC00);
    check("arm_quiet", 128'(bus.q), 128'h0);

    for (int i = 0; i < 16; i++) step(12'(i), 4'hF, $urandom, 1'b1);

    step(12'h005, 4'hF, 32'hDEADBEEF, 1'b1);
    step(12'h005, 4'h1, 32'h000000AA, 1'b1);
    check("ram_rdw_old", 128'(bus.q), 128'hDEADBEEF);
    rd(12'h005);
    check("ram_merge", 128'(bus.q), 128'hDEADBEAA);

    step(12'h800, 4'hF, 32'h000003FF, 1'b1);
    check("out0_bus", 128'(io_out[9:0]), 128'h3FF);
    rd(12'h800);
    check("out0_rd", 128'(bus.q), 128'h3FF);
    snap = io_out;
    step(12'h807, 4'hF, $urandom, 1'b1);
    check("out_oob_wr", 128'(io_out), 128'(snap));
    rd(12'h807);
    check("out_oob_rd", 128'(bus.q), 128'h0);

    io_in[2*IN_W +: IN_W] = 10'h155;
    rd(12'h402);
    rd(12'h402);
    check("in_early", 128'(bus.q), 128'h0AA);
    rd(12'h402);
    check("in_lat3", 128'(bus.q), 128'h155);
    rd(12'hC00);
    check("evt_bit2", 128'(bus.q[2]), 128'h1);
    check("evt_out", 128'(io_evt), 128'h1);
    step(12'hC00, 4'h0, 32'h4, 1'b1);
    rd(12'hC00);
    check("evt_clr", 128'(bus.q[2]), 128'h0);
    check("evt_out_clr", 128'(io_evt), 128'h0);

    // W1C lands on the very edge where channel 1's change is detected
    io_in[IN_W +: IN_W] = io_in[IN_W +: IN_W] ^ 10'h001;
    rd(12'hC00);
    rd(12'hC00);
    step(12'hC00, 4'hF, 32'h2, 1'b1);
    rd(12'hC00);
    check("set_wins", 128'(bus.q[1]), 128'h1);
    step(12'hC00, 4'hF, 32'h2, 1'b1);
    rd(12'hC00);

    for (int n = 0; n < 400; n++) begin
      logic [1:0] r;
      logic [3:0] ix;
      r  = 2'($urandom_range(0, 3));
      ix = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        int ch;
        ch = $urandom_range(0, N_IN-1);
        io_in[ch*IN_W +: IN_W] = IN_W'($urandom);
      end
      step({r, 6'b0, ix}, 4'($urandom), $urandom, 1'($urandom_range(0, 1)));
    end

    // Mid-stream reset with outputs written and an event pending
    step(12'h803, 4'hF, 32'h2A5, 1'b1);
    step(12'h003, 4'hF, 32'hCAFEF00D, 1'b1);
    io_in[0 +: IN_W] = ~io_in[0 +: IN_W];
    for (int i = 0; i < 4; i++) rd(12'h803);
    check("pre_rst_evt", 128'(io_evt), 128'h1);
    bus.address = 12'h003; bus.byteena = 4'hF; bus.data = 32'h12345678; bus.wren = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async_q", 128'(bus.q), 128'h0);
    check("async_out", 128'(io_out), 128'h0);
    check("async_evt", 128'(io_evt), 128'h0);
    @(posedge clock);
    @(negedge clock);
    bus.wren = 1'b0;
    reset = 1'b0;
    model_reset();
    rd(12'h003);
    check("rst_write_lost", 128'(bus.q), 128'hCAFEF00D);
    for (int i = 0; i < 6; i++) rd(12'hC00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
